// File: rtl/fx_add_pkg.sv
// Shared constants and width helpers for the fixed-point adder scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fx_add_pkg;

    // Number formats understood by fx_pt_add
    localparam int SGN_UNSIGNED = 0;
    localparam int SGN_TWOS     = 1;
    localparam int SGN_SIGNMAG  = 2;

    // Adder output width: room for full alignment shift plus carry/sign
    function automatic int sum_w(input int width);
        return 2 * width + 1;
    endfunction

    // Requester index width, never narrower than one bit
    function automatic int id_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/fx_pt_add.sv
// Combinational fixed-point adder: a is shifted left by A_INT_W, b by B_INT_W,
// so the sum carries WIDTH fractional bits. Latency: 0 cycles. Backpressure: none.
// Ports: a, b (WIDTH, format SGN) -> sum (2*WIDTH+1, same format).
// Sign-magnitude results with zero magnitude are always +0.
module fx_pt_add
    import fx_add_pkg::*;
#(
    parameter int SGN     = 2,
    parameter int WIDTH   = 15,
    parameter int A_INT_W = 14,
    parameter int B_INT_W = 1
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH:0]   sum
);

    localparam int SW = 2 * WIDTH + 1;
    localparam int MW = 2 * WIDTH;

    generate
        if (SGN == SGN_UNSIGNED) begin : g_unsigned
            assign sum = (SW'(a) << A_INT_W) + (SW'(b) << B_INT_W);
        end else if (SGN == SGN_TWOS) begin : g_twos
            logic signed [SW-1:0] xa;
            logic signed [SW-1:0] xb;
            assign xa  = SW'($signed(a));
            assign xb  = SW'($signed(b));
            assign sum = (xa <<< A_INT_W) + (xb <<< B_INT_W);
        end else begin : g_signmag
            logic [MW-1:0] ma;
            logic [MW-1:0] mb;
            logic [MW-1:0] mag;
            logic          sa;
            logic          sb;
            logic          sgn;
            assign sa = a[WIDTH-1];
            assign sb = b[WIDTH-1];
            assign ma = MW'(a[WIDTH-2:0]) << A_INT_W;
            assign mb = MW'(b[WIDTH-2:0]) << B_INT_W;
            always_comb begin
                mag = '0;
                sgn = 1'b0;
                if (sa == sb) begin
                    mag = ma + mb;
                    sgn = sa;
                end else if (ma >= mb) begin
                    mag = ma - mb;
                    sgn = sa;
                end else begin
                    mag = mb - ma;
                    sgn = sb;
                end
                // Never emit negative zero
                if (mag == '0) begin
                    sgn = 1'b0;
                end
            end
            assign sum = {sgn, mag};
        end
    endgenerate

endmodule

// File: rtl/fx_add_sched.sv
// Round-robin scheduler sharing one fx_pt_add among N_REQ requesters.
// Latency: 2 cycles grant-to-result; 1 result/cycle while res_ready is high.
// Backpressure: res_ready low stalls S2 then S1; req_ready drops once both are full.
// Ports: req_valid/req_a/req_b/req_ready per requester (packed i*WIDTH),
//        res_valid/res_ready/res_sum/res_id result channel, op_count transfers.
module fx_add_sched
    import fx_add_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int WIDTH   = 15,
    parameter  int SGN     = 2,
    parameter  int A_INT_W = 14,
    parameter  int B_INT_W = 1,
    localparam int SUM_W   = sum_w(WIDTH),
    localparam int ID_W    = id_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SUM_W-1:0]       res_sum,
    output logic [ID_W-1:0]        res_id,
    output logic [15:0]            op_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [ID_W-1:0]  s1_id;
    logic             s2_valid;
    logic [ID_W-1:0]  rr_ptr;

    logic             s2_adv;
    logic             s1_free;
    logic             res_xfer;
    logic [N_REQ-1:0] rot;
    logic             found;
    logic [ID_W:0]    win_ext;
    logic [ID_W-1:0]  win;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [SUM_W-1:0] add_sum;

    assign s2_adv   = s1_valid & (~s2_valid | res_ready);
    assign s1_free  = ~s1_valid | s2_adv;
    assign res_xfer = s2_valid & res_ready;
    assign res_valid = s2_valid;

    // Rotate the request vector so bit 0 is the requester at rr_ptr; the
    // lowest set bit of the rotated vector is the round-robin winner.
    assign rot = N_REQ'({req_valid, req_valid} >> rr_ptr);

    always_comb begin
        found   = 1'b0;
        win_ext = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found   = 1'b1;
                win_ext = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            end
        end
        if (win_ext >= (ID_W + 1)'(N_REQ)) begin
            win_ext = win_ext - (ID_W + 1)'(N_REQ);
        end
    end

    assign win = win_ext[ID_W-1:0];

    // Grant only when S1 can take the operands; held off during reset.
    always_comb begin
        req_ready = '0;
        if (s1_free && found && !rst) begin
            req_ready = N_REQ'(1) << win;
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) begin
                win_a = req_a[i*WIDTH +: WIDTH];
                win_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    fx_pt_add #(
        .SGN     (SGN),
        .WIDTH   (WIDTH),
        .A_INT_W (A_INT_W),
        .B_INT_W (B_INT_W)
    ) u_add (
        .a   (s1_a),
        .b   (s1_b),
        .sum (add_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            res_sum  <= '0;
            res_id   <= '0;
            rr_ptr   <= '0;
            op_count <= '0;
        end else begin
            // req_ready is nonzero exactly when a grant exists, and the
            // granted requester is valid, so any grant is a transfer.
            if (|req_ready) begin
                s1_valid <= 1'b1;
                s1_a     <= win_a;
                s1_b     <= win_b;
                s1_id    <= win;
                rr_ptr   <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                s2_valid <= 1'b1;
                res_sum  <= add_sum;
                res_id   <= s1_id;
            end else if (res_xfer) begin
                s2_valid <= 1'b0;
            end

            if (res_xfer) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fx_add_sched.sv
// Directed bench for fx_add_sched with a result scoreboard.
// Latency: n/a. Backpressure: res_ready driven by the directed steps.
module tb_fx_add_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [59:0] req_a;
    logic [59:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [30:0] res_sum;
    logic [1:0]  res_id;
    logic [15:0] op_count;

    logic [14:0] op_a [4];
    logic [14:0] op_b [4];

    typedef struct packed {
        logic [1:0]  id;
        logic [30:0] sum;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          exp_ops = 0;
    logic        hold = 1'b0;
    logic [30:0] held_sum = '0;
    logic [1:0]  held_id = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_a[i*15 +: 15] = op_a[i];
            req_b[i*15 +: 15] = op_b[i];
        end
    end

    fx_add_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    // Sign-magnitude, a weighted 2^14 and b weighted 2^1 relative to the sum LSB
    function automatic logic [30:0] ref_sum(input logic [14:0] a, input logic [14:0] b);
        longint va;
        longint vb;
        longint s;
        va = longint'(a[13:0]) * 16384;
        if (a[14]) va = -va;
        vb = longint'(b[13:0]) * 2;
        if (b[14]) vb = -vb;
        s = va + vb;
        if (s < 0) return {1'b1, 30'(-s)};
        return {1'b0, 30'(s)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accepted request, pop on result handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_ops = 0;
            hold = 1'b0;
        end else begin
            chk("grant_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            if (hold) begin
                chk("hold_sum", 64'(res_sum), 64'(held_sum));
                chk("hold_id", 64'(res_id), 64'(held_id));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(res_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_sum", 64'(res_sum), 64'(e.sum));
                    chk("sb_id", 64'(res_id), 64'(e.id));
                end
                exp_ops = exp_ops + 1;
            end
            hold = res_valid && !res_ready;
            held_sum = res_sum;
            held_id = res_id;
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back({2'(i), ref_sum(op_a[i], op_b[i])});
                end
            end
        end
    end

    task automatic send_one(input int id, input logic [14:0] a, input logic [14:0] b,
                            input logic [30:0] exp_sum, input string tag);
        op_a[id] = a;
        op_b[id] = b;
        req_valid = 4'(1 << id);
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(1 << id));
        tick();
        req_valid = '0;
        chk({tag, "_lat1"}, 64'(res_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_sum"}, 64'(res_sum), 64'(exp_sum));
        chk({tag, "_id"}, 64'(res_id), 64'(id));
        tick();
        chk({tag, "_done"}, 64'(res_valid), 64'd0);
        chk({tag, "_count"}, 64'(op_count), 64'(exp_ops));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        // Reset: ready must stay low even with every requester valid
        req_valid = 4'hF;
        tick();
        chk("ready_in_reset", 64'(req_ready), 64'd0);
        tick();
        req_valid = '0;
        rst = 1'b0;
        tick();
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_res_sum", 64'(res_sum), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);

        // Single requests with known sign-magnitude results
        send_one(2, 15'h0001, 15'h0001, 31'h0000_4002, "single");
        chk("count_one", 64'(op_count), 64'd1);
        send_one(1, 15'h4001, 15'h0001, 31'h4000_3FFE, "mixed");
        send_one(3, 15'h4000, 15'h4000, 31'h0000_0000, "negzero");

        // Fresh reset, then all four requesters continuously valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 15'($urandom_range(0, 32767));
            op_b[i] = 15'($urandom_range(0, 32767));
        end
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_grant", 64'(req_ready), 64'(1 << (c % 4)));
            tick();
            if (c >= 1) begin
                chk("rr_res_valid", 64'(res_valid), 64'd1);
                chk("rr_res_id", 64'(res_id), 64'((c - 1) % 4));
            end
        end

        // Fairness: after 2, only 0 and 3 request -> 3 then 0
        req_valid = 4'b0100;
        #1;
        chk("fair_g2", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b1001;
        #1;
        chk("fair_g3", 64'(req_ready), 64'b1000);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("fair_g0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("fair_count", 64'(op_count), 64'(exp_ops));

        // Backpressure: rr_ptr is 1, both stages fill with requesters 1 and 2
        res_ready = 1'b0;
        req_valid = 4'hF;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            n += $countones(req_valid & req_ready);
            tick();
        end
        chk("bp_transfers", 64'(n), 64'd2);
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        chk("bp_res_valid", 64'(res_valid), 64'd1);
        chk("bp_res_id", 64'(res_id), 64'd1);
        chk("bp_count", 64'(op_count), 64'(exp_ops));
        res_ready = 1'b1;
        #1;
        chk("bp_same_cycle_grant", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        chk("bp_drain_id2", 64'(res_id), 64'd2);
        tick();
        chk("bp_drain_id3", 64'(res_id), 64'd3);
        chk("bp_drain_valid", 64'(res_valid), 64'd1);
        tick();
        chk("bp_drained", 64'(res_valid), 64'd0);

        // Reset with both stages full: nothing from before reset may appear
        res_ready = 1'b0;
        req_valid = 4'hF;
        repeat (3) tick();
        chk("full_before_rst", 64'(res_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("ready_in_reset2", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        chk("rst2_res_valid", 64'(res_valid), 64'd0);
        chk("rst2_op_count", 64'(op_count), 64'd0);
        #1;
        chk("rst2_first_grant", 64'(req_ready), 64'b0001);
        req_valid = 4'b1100;
        #1;
        chk("rst2_lowest_valid", 64'(req_ready), 64'b0100);
        res_ready = 1'b1;
        tick();
        req_valid = '0;
        repeat (4) tick();
        chk("rst2_count", 64'(op_count), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fx_add_sched.md
# fx_add_sched

Round-robin scheduler that shares one fixed-point adder (`fx_pt_add`) among `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one request per cycle, registers the operands, adds them and registers the result. The result leaves with the winning requester's ID over a valid/ready output channel with full backpressure. It sits between the per-channel fixed-point producers and the accumulation/writeback stage.

## Interface
- `N_REQ`, 4, number of requesters (2..16).
- `WIDTH`, 15, operand width, passed to the adder.
- `SGN`, 2, number format, passed to the adder: 0 unsigned, 1 two's complement, 2 sign-magnitude.
- `A_INT_W`, 14, alignment parameter for operand a, passed to the adder.
- `B_INT_W`, 1, alignment parameter for operand b, passed to the adder.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_a`  in  N_REQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH  operand b; same packing as `req_a`.
- `req_ready`  out  N_REQ  one-hot-or-zero grant; transfer occurs when `req_valid[i] & req_ready[i]`.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  downstream accepts the result.
- `res_sum`  out  2*WIDTH+1  adder sum, in the adder's output format.
- `res_id`  out  ID_W = max(1, clog2(N_REQ))  index of the requester that produced `res_sum`.
- `op_count`  out  16  count of completed result transfers; wraps at 65535 -> 0.

## Operation
- Two-stage pipeline:
  - S1 holds operands and ID (`s1_valid`, `s1_a`, `s1_b`, `s1_id`).
  - The adder is combinational from S1.
  - S2 holds `res_sum` and `res_id`; `s2_valid` drives `res_valid`.
- Advance rules:
  - `s2_adv = s1_valid & (!s2_valid | res_ready)`.
  - `s1_free = !s1_valid | s2_adv`.
- Grant rules:
  - Computed only when `s1_free`; otherwise `req_ready` is all zero.
  - The winner is the first i with `req_valid[i]` set, searching from pointer `rr_ptr` upward and wrapping from N_REQ-1 to 0.
  - `req_ready` is combinational from `req_valid`, `rr_ptr`, `s1_valid`, `s2_valid` and `res_ready`.
- On a transfer:
  - S1 loads the winner's a, b and ID, and `s1_valid` is set.
  - `rr_ptr` becomes (winner+1) mod N_REQ.
- With no transfer, `rr_ptr` holds. If S1 advances with no new transfer, `s1_valid` clears.
- On `s2_adv`, S2 loads the adder sum and `s1_id`, and `s2_valid` is set. On `res_valid & res_ready` with no `s2_adv`, `s2_valid` clears.
- `op_count` increments on every `res_valid & res_ready`.
- Requester obligation: hold `req_valid` and operands stable until ready. Deasserting valid without a transfer is legal; that request is dropped with no side effects.
- `res_sum`/`res_id` are stable while `res_valid & !res_ready`.
- Arithmetic: the block adds no rounding, saturation or widening; width and format are exactly the adder's. Sign-magnitude negative-zero handling is the adder's.

## Timing
- Reset values: `s1_valid`=0, `s2_valid`=0 (so `res_valid`=0), `rr_ptr`=0, `res_sum`=0, `res_id`=0, `op_count`=0.
- During reset `req_ready`=0. Reset mid-operation discards all in-flight operations and no result is emitted for them.
- Latency: a request accepted at edge k gives `res_valid`=1 after edge k+1, i.e. 2 cycles.
- Throughput: 1 result per cycle while `res_ready`=1.
- Backpressure with `res_ready` held low:
  - S2 fills first, then S1.
  - After at most 2 accepted requests, `req_ready` stays 0 until `res_ready` rises.
  - The same-cycle rule gives no bubble: when `res_ready`=1 and both stages are full, S2 drains, S1 moves to S2, and a new grant is issued in that same cycle.
- Simultaneous requests: exactly one grant per cycle. Non-winners keep waiting.
- With all N_REQ requesting continuously, each requester is granted exactly once every N_REQ accepted cycles.

## Structure
- Shared package `fx_add_pkg`:
  - Format constants `SGN_UNSIGNED`=0, `SGN_TWOS`=1, `SGN_SIGNMAG`=2.
  - Width helpers: `SUM_W` = 2*WIDTH+1, `ID_W` as in the port list.
- One child instance: `fx_pt_add`, parameterised with `SGN`, `WIDTH`, `A_INT_W`, `B_INT_W`. Inputs are `s1_a`/`s1_b`; its `sum` feeds S2.
- Round-robin search and pipeline control are inline; no further sub-modules.

## Test plan
- Single request, defaults (SGN=2), `res_ready`=1. Requester 2 sends a=15'h0001, b=15'h0001 at edge k -> after edge k+1, `res_valid`=1, `res_sum`=31'h0000_4002, `res_id`=2. Then `op_count`=1.
- Sign-magnitude mixed and negative zero:
  - a=15'h4001, b=15'h0001 -> `res_sum`=31'h4000_3FFE.
  - a=15'h4000, b=15'h4000 -> `res_sum`=0.
- All 4 requesters valid from reset, `res_ready`=1 -> grants in order 0,1,2,3,0,…, one per cycle; `res_id` sequence 0,1,2,3 starting 2 cycles after the first grant.
- Fairness: after a grant to 2, only requesters 0 and 3 are valid -> 3 is granted, then 0.
- Backpressure: 4 requesters valid, `res_ready`=0 for 6 cycles -> exactly 2 transfers, then `req_ready`=0. `res_sum`/`res_id` stay stable. On `res_ready`=1, results drain in order and a new grant is issued in the same cycle.
- Reset with both stages full: assert `rst` for 1 cycle -> next cycle `res_valid`=0, `op_count`=0, `rr_ptr`=0 (first grant goes to the lowest valid index). No stale result appears.
